uart_rx_fifo: RTL and testbench

- Receive-side elastic buffer placed directly downstream of the UART receiver.
- Accepts each received byte and its parity-error flag over an AXI-Stream-style slave port, stores them in a first-word-fall-through FIFO, and presents them to the host-side consumer on a master port.
- Decouples consumer latency from UART frame timing; the receiver overwrites an unread byte once the next frame completes.
- Provides fill level, a sticky backpressure flag and a saturating parity-error count for status registers.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_fifo_ram.sv | 34 +++
 rtl/uart_rx_fifo.sv | 178 +++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: parity check modes, the
// default data width and the width of one buffered receive entry.
package uart_pkg;

  // Parity check modes understood by the receiver's check_flag logic.
  localparam logic [2:0] CHECK_NONE = 3'd0;
  localparam logic [2:0] CHECK_EVEN = 3'd1;
  localparam logic [2:0] CHECK_ODD  = 3'd2;
  localparam logic [2:0] CHECK_ZERO = 3'd3;
  localparam logic [2:0] CHECK_ONE  = 3'd4;

  // Width of one received character.
  localparam int DEFAULT_DATA_BITS = 8;

  // One buffered entry: {parity_error_flag, data}.
  localparam int FIFO_ENTRY_BITS = DEFAULT_DATA_BITS + 1;

  // One buffered entry as a packed record.
  typedef struct packed {
    logic                         perr;
    logic [DEFAULT_DATA_BITS-1:0] data;
  } rx_entry_t;

endpackage

// File: rtl/uart_fifo_ram.sv
// Simple dual-port storage for the receive FIFO: one synchronous write port
// and one read port whose output is registered. Storage is not reset.
// A read of the address being written on the same edge returns the old word.
module uart_fifo_ram
  import uart_pkg::*;
#(
  parameter int ADDR_BITS = 4,
  parameter int WIDTH     = FIFO_ENTRY_BITS
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [WIDTH-1:0]     rdata
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [WIDTH-1:0] mem [0:DEPTH-1];

  // Write port: store the incoming word on a qualified edge.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port: register the addressed word every cycle.
  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side elastic buffer behind the UART receiver. Bytes and their
// parity-error flags enter on an AXI-Stream slave port, are held in a
// first-word-fall-through FIFO and leave on a master port. Also keeps the
// fill level, a sticky backpressure flag and a saturating parity-error count.
//
// The head of the FIFO is shown through two registered sources: the RAM's
// registered read (addressed with the post-edge read pointer) or a bypass
// register that captures a byte landing directly at the head on this edge.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int ADDR_BITS    = 4,
  parameter int DATA_BITS    = DEFAULT_DATA_BITS,
  parameter bit DROP_BAD     = 1'b0,
  parameter int ERR_CNT_BITS = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic [DATA_BITS-1:0]    s_axis_tdata,
  input  logic                    s_axis_tuser,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic [DATA_BITS-1:0]    m_axis_tdata,
  output logic                    m_axis_tuser,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [ADDR_BITS:0]      fill_level,
  output logic                    stall_flag,
  output logic [ERR_CNT_BITS-1:0] err_cnt
);

  localparam int ENTRY_W = DATA_BITS + 1;
  localparam int PTR_W   = ADDR_BITS + 1;

  localparam logic [PTR_W-1:0]        PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_CNT_BITS-1:0] ERR_ONE = {{(ERR_CNT_BITS-1){1'b0}}, 1'b1};
  localparam logic [ERR_CNT_BITS-1:0] ERR_MAX = {ERR_CNT_BITS{1'b1}};

  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [PTR_W-1:0]        wr_ptr_next;
  logic [PTR_W-1:0]        rd_ptr_next;
  logic [PTR_W-1:0]        fill_next;
  logic [PTR_W-1:0]        fill_reg;
  logic                    full;
  logic                    wr_accept;
  logic                    wr_store;
  logic                    rd_pop;
  logic                    head_is_new;
  logic                    out_valid;
  logic                    sel_byp;
  logic [ENTRY_W-1:0]      byp_entry;
  logic [ENTRY_W-1:0]      ram_q;
  logic [ENTRY_W-1:0]      head_entry;
  logic                    stall_reg;
  logic [ERR_CNT_BITS-1:0] err_reg;

  // Full when the wrap bits differ and the address bits match.
  assign full = (wr_ptr[ADDR_BITS] != rd_ptr[ADDR_BITS]) &&
                (wr_ptr[ADDR_BITS-1:0] == rd_ptr[ADDR_BITS-1:0]);

  // Ready depends only on registered pointers; held low while in reset.
  assign s_axis_tready = !full && !rst;

  assign wr_accept = s_axis_tvalid && s_axis_tready;
  // A flagged byte still completes its handshake but is not stored when dropping.
  assign wr_store  = wr_accept && !(DROP_BAD && s_axis_tuser);
  assign rd_pop    = out_valid && m_axis_tready;

  assign head_entry    = sel_byp ? byp_entry : ram_q;
  assign m_axis_tdata  = head_entry[DATA_BITS-1:0];
  assign m_axis_tuser  = head_entry[DATA_BITS];
  assign m_axis_tvalid = out_valid;
  assign fill_level    = fill_reg;
  assign stall_flag    = stall_reg;
  assign err_cnt       = err_reg;

  // Next pointer values and whether the post-edge head is the byte written now.
  always_comb begin
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    head_is_new = 1'b0;
    if (clr) begin
      wr_ptr_next = {PTR_W{1'b0}};
      rd_ptr_next = {PTR_W{1'b0}};
      head_is_new = 1'b0;
    end else begin
      if (wr_store) begin
        wr_ptr_next = wr_ptr + PTR_ONE;
      end else begin
        wr_ptr_next = wr_ptr;
      end
      if (rd_pop) begin
        rd_ptr_next = rd_ptr + PTR_ONE;
      end else begin
        rd_ptr_next = rd_ptr;
      end
      // The slot written this edge becomes the head when it is the next read slot.
      head_is_new = wr_store && (wr_ptr == rd_ptr_next);
    end
    fill_next = wr_ptr_next - rd_ptr_next;
  end

  uart_fifo_ram #(
    .ADDR_BITS (ADDR_BITS),
    .WIDTH     (ENTRY_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_store && !clr),
    .waddr (wr_ptr[ADDR_BITS-1:0]),
    .wdata ({s_axis_tuser, s_axis_tdata}),
    .raddr (rd_ptr_next[ADDR_BITS-1:0]),
    .rdata (ram_q)
  );

  // Pointers, fill level and output valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= {PTR_W{1'b0}};
      rd_ptr    <= {PTR_W{1'b0}};
      fill_reg  <= {PTR_W{1'b0}};
      out_valid <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr_next;
      rd_ptr    <= rd_ptr_next;
      fill_reg  <= fill_next;
      out_valid <= (fill_next != {PTR_W{1'b0}});
    end
  end

  // Head source selection: bypass a byte landing at the head, hold when empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_byp   <= 1'b1;
      byp_entry <= {ENTRY_W{1'b0}};
    end else if (clr) begin
      sel_byp   <= 1'b1;
      byp_entry <= {ENTRY_W{1'b0}};
    end else if (head_is_new) begin
      sel_byp   <= 1'b1;
      byp_entry <= {s_axis_tuser, s_axis_tdata};
    end else if (fill_next == {PTR_W{1'b0}}) begin
      sel_byp   <= 1'b1;
      byp_entry <= head_entry;
    end else begin
      sel_byp   <= 1'b0;
      byp_entry <= byp_entry;
    end
  end

  // Sticky flag: a byte was offered while the FIFO could not take it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_reg <= 1'b0;
    end else if (clr) begin
      stall_reg <= 1'b0;
    end else if (s_axis_tvalid && !s_axis_tready) begin
      stall_reg <= 1'b1;
    end else begin
      stall_reg <= stall_reg;
    end
  end

  // Saturating count of accepted bytes carrying a parity error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_reg <= {ERR_CNT_BITS{1'b0}};
    end else if (clr) begin
      err_reg <= {ERR_CNT_BITS{1'b0}};
    end else if (wr_accept && s_axis_tuser && (err_reg != ERR_MAX)) begin
      err_reg <= err_reg + ERR_ONE;
    end else begin
      err_reg <= err_reg;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: two instances (default build, and a dropping build
// with a 2-bit error counter) share one directed stimulus. A queue model of
// each instance is compared on every falling edge; directed literal checks
// pin the model to hand-computed values.
module tb_uart_rx_fifo;

  logic       clk     = 1'b0;
  logic       rst     = 1'b0;
  logic       clr     = 1'b0;
  logic [7:0] s_data  = 8'h00;
  logic       s_user  = 1'b0;
  logic       s_valid = 1'b0;
  logic       m_ready = 1'b0;

  logic        a_s_ready, a_m_user, a_m_valid, a_stall;
  logic [7:0]  a_m_data;
  logic [4:0]  a_fill;
  logic [15:0] a_err;
  logic        b_s_ready, b_m_user, b_m_valid, b_stall;
  logic [7:0]  b_m_data;
  logic [4:0]  b_fill;
  logic [1:0]  b_err;

  int total = 0;
  int bad   = 0;

  logic [8:0] qa[$];
  logic [8:0] qb[$];
  int         err_a = 0;
  int         err_b = 0;
  bit         stall_a = 1'b0;
  bit         stall_b = 1'b0;

  always #5 clk = ~clk;

  uart_rx_fifo u_a (
    .clk(clk), .rst(rst), .clr(clr),
    .s_axis_tdata(s_data), .s_axis_tuser(s_user), .s_axis_tvalid(s_valid),
    .s_axis_tready(a_s_ready),
    .m_axis_tdata(a_m_data), .m_axis_tuser(a_m_user), .m_axis_tvalid(a_m_valid),
    .m_axis_tready(m_ready),
    .fill_level(a_fill), .stall_flag(a_stall), .err_cnt(a_err)
  );

  uart_rx_fifo #(.DROP_BAD(1'b1), .ERR_CNT_BITS(2)) u_b (
    .clk(clk), .rst(rst), .clr(clr),
    .s_axis_tdata(s_data), .s_axis_tuser(s_user), .s_axis_tvalid(s_valid),
    .s_axis_tready(b_s_ready),
    .m_axis_tdata(b_m_data), .m_axis_tuser(b_m_user), .m_axis_tvalid(b_m_valid),
    .m_axis_tready(m_ready),
    .fill_level(b_fill), .stall_flag(b_stall), .err_cnt(b_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic u, input logic mr);
    s_valid = v;
    s_data  = d;
    s_user  = u;
    m_ready = mr;
  endtask

  // Model: a FIFO of at most 16 entries; ready is decided before the edge.
  initial begin
    bit rdy_a, rdy_b;
    forever begin
      @(posedge clk or posedge rst);
      if (rst || clr) begin
        qa.delete(); qb.delete();
        err_a = 0; err_b = 0; stall_a = 1'b0; stall_b = 1'b0;
      end else begin
        rdy_a = (qa.size() < 16);
        rdy_b = (qb.size() < 16);
        if (m_ready && qa.size() > 0) void'(qa.pop_front());
        if (m_ready && qb.size() > 0) void'(qb.pop_front());
        if (s_valid && !rdy_a) stall_a = 1'b1;
        if (s_valid && !rdy_b) stall_b = 1'b1;
        if (s_valid && rdy_a) begin
          qa.push_back({s_user, s_data});
          if (s_user && err_a < 65535) err_a++;
        end
        if (s_valid && rdy_b) begin
          if (!s_user) qb.push_back({s_user, s_data});
          if (s_user && err_b < 3) err_b++;
        end
      end
    end
  end

  // Compare both instances against the model on every falling edge.
  initial begin
    logic [8:0] ea, eb;
    forever begin
      @(negedge clk);
      check("cmp_a_ready", a_s_ready, (!rst && qa.size() < 16));
      check("cmp_a_valid", a_m_valid, (qa.size() > 0));
      check("cmp_a_fill", a_fill, 32'(qa.size()));
      check("cmp_a_stall", a_stall, stall_a);
      check("cmp_a_err", a_err, err_a);
      if (qa.size() > 0) begin
        ea = qa[0];
        check("cmp_a_data", a_m_data, ea[7:0]);
        check("cmp_a_user", a_m_user, ea[8]);
      end
      check("cmp_b_ready", b_s_ready, (!rst && qb.size() < 16));
      check("cmp_b_valid", b_m_valid, (qb.size() > 0));
      check("cmp_b_fill", b_fill, 32'(qb.size()));
      check("cmp_b_stall", b_stall, stall_b);
      check("cmp_b_err", b_err, err_b);
      if (qb.size() > 0) begin
        eb = qb[0];
        check("cmp_b_data", b_m_data, eb[7:0]);
        check("cmp_b_user", b_m_user, eb[8]);
      end
    end
  end

  // Directed stimulus with hand-computed literal expectations.
  initial begin
    #1 rst = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (3) cyc();
    check("rst_s_ready", a_s_ready, 0);
    check("rst_fill", a_fill, 0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", a_s_ready, 1);
    check("post_rst_valid", a_m_valid, 0);
    check("post_rst_data", a_m_data, 8'h00);
    check("post_rst_user", a_m_user, 0);
    check("post_rst_stall", a_stall, 0);
    check("post_rst_err", a_err, 0);
    repeat (5) cyc();

    // Single byte, consumer not ready: appears one edge later and holds.
    drive(1'b1, 8'h55, 1'b0, 1'b0);
    cyc();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("first_valid", a_m_valid, 1);
    check("first_data", a_m_data, 8'h55);
    check("first_fill", a_fill, 1);
    check("first_err", a_err, 0);
    cyc();
    check("first_hold", a_m_data, 8'h55);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    cyc();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("first_pop_valid", a_m_valid, 0);

    // Fill to 16, hold a 17th byte, pop once, then drain.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, i[7:0], 1'b0, 1'b0);
      cyc();
    end
    check("full_fill", a_fill, 16);
    check("full_ready", a_s_ready, 0);
    drive(1'b1, 8'hAA, 1'b0, 1'b0);
    cyc();
    cyc();
    check("full_stall", a_stall, 1);
    check("full_fill_held", a_fill, 16);
    check("full_head", a_m_data, 8'h00);
    drive(1'b1, 8'hAA, 1'b0, 1'b1);
    cyc();
    check("pop_full_fill", a_fill, 15);
    check("pop_full_ready", a_s_ready, 1);
    drive(1'b1, 8'hAA, 1'b0, 1'b0);
    cyc();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("aa_accepted_fill", a_fill, 16);
    for (int i = 1; i <= 16; i++) begin
      logic [7:0] exp_d;
      exp_d = (i == 16) ? 8'hAA : i[7:0];
      check("drain_order", a_m_data, exp_d);
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      cyc();
    end
    check("drain_empty", a_m_valid, 0);

    // Full-rate streaming of 40 bytes.
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 8'h80 + i[7:0], 1'b0, 1'b1);
      cyc();
      check("stream_data", a_m_data, 8'h80 + i[7:0]);
      check("stream_fill", a_fill, 1);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    cyc();
    check("stream_end_valid", a_m_valid, 0);

    // Parity-error byte: kept by the default build, dropped by the other.
    drive(1'b1, 8'h11, 1'b0, 1'b0); cyc();
    drive(1'b1, 8'h22, 1'b1, 1'b0); cyc();
    drive(1'b1, 8'h33, 1'b0, 1'b0); cyc();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("keep_fill", a_fill, 3);
    check("drop_fill", b_fill, 2);
    check("keep_err", a_err, 1);
    check("drop_err", b_err, 1);
    check("drop_head0", b_m_data, 8'h11);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    cyc();
    check("keep_head1", a_m_data, 8'h22);
    check("keep_user1", a_m_user, 1);
    check("drop_head1", b_m_data, 8'h33);
    check("drop_user1", b_m_user, 0);
    cyc();
    cyc();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("keep_drained", a_m_valid, 0);

    // Asynchronous reset with 7 entries stored.
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 8'h40 + i[7:0], 1'b0, 1'b0);
      cyc();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("pre_rst_fill", a_fill, 7);
    check("pre_rst_stall", a_stall, 1);
    rst = 1'b1;
    #1;
    check("rst_now_fill", a_fill, 0);
    check("rst_now_valid", a_m_valid, 0);
    check("rst_now_stall", a_stall, 0);
    check("rst_now_err", a_err, 0);
    check("rst_now_ready", a_s_ready, 0);
    cyc();
    rst = 1'b0;
    drive(1'b1, 8'h77, 1'b0, 1'b0);
    cyc();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("rst_next_data", a_m_data, 8'h77);
    check("rst_next_fill", a_fill, 1);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    cyc();

    // Synchronous clear after filling with mixed error bytes and a stall.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 8'hC0 + i[7:0], (i % 2 == 0), 1'b0);
      cyc();
    end
    drive(1'b1, 8'hD0, 1'b0, 1'b0);
    cyc();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("pre_clr_fill", a_fill, 16);
    check("pre_clr_stall", a_stall, 1);
    check("pre_clr_err", a_err, 8);
    check("pre_clr_b_err_sat", b_err, 3);
    check("pre_clr_b_fill", b_fill, 9);
    clr = 1'b1;
    #1;
    check("clr_before_edge", a_fill, 16);
    cyc();
    clr = 1'b0;
    check("clr_fill", a_fill, 0);
    check("clr_valid", a_m_valid, 0);
    check("clr_stall", a_stall, 0);
    check("clr_err", a_err, 0);
    check("clr_b_err", b_err, 0);
    check("clr_b_fill", b_fill, 0);
    drive(1'b1, 8'h77, 1'b0, 1'b0);
    cyc();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("clr_next_data", a_m_data, 8'h77);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    cyc();

    // Saturation of the 2-bit error counter.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'hE0 + i[7:0], 1'b1, 1'b1);
      cyc();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    cyc();
    check("sat_b_err", b_err, 3);
    check("sat_a_err", a_err, 5);
    check("sat_b_fill", b_fill, 0);
    cyc();
    check("sat_b_hold", b_err, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
